uart_word_tx: RTL and testbench

Transmit-side UART for the board's serial link. It accepts a 32-bit word through a valid/ready handshake and serialises it as four back-to-back 8N1 frames on `TxD`, least-significant byte first. This byte order is the same one the receive-side buffer filler uses to reassemble instruction words. It runs on the 10 MHz core clock and is used to stream register or memory contents back to the host.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_byte_if.sv | 13 +
 rtl/uart_tx_byte.sv | 114 +++++++++++
 rtl/uart_word_tx.sv | 83 ++++++++
 tb/tb_uart_word_tx.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and framing constants for the transmit and receive paths.
// Used by uart_tx_byte and uart_word_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int   UART_DATA_BITS      = 8;
    localparam int   UART_BYTES_PER_WORD = 4;
    localparam logic UART_IDLE_LEVEL     = 1'b1;

endpackage

// File: rtl/uart_byte_if.sv
// Byte-level valid/ready handshake between the word wrapper and the frame
// serialiser.
interface uart_byte_if;
    import uart_pkg::*;

    logic                      valid;
    logic                      ready;
    logic [UART_DATA_BITS-1:0] data;

    modport src (output valid, output data, input ready);
    modport snk (input valid, input data, output ready);

endinterface

// File: rtl/uart_tx_byte.sv
// Single-frame serialiser: start, 8 data bits LSB first, optional even parity
// (UART_TX_PARITY_EN), stop.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    uart_byte_if.snk    byte_if,
    output logic        txd_o
);

    localparam int            BW       = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] LAST_CLK = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    tx_state_t                 state_q, state_d;
    logic [BW-1:0]             baud_q, baud_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      txd_q, txd_d;
    logic                      tick;

    assign tick  = (baud_q == LAST_CLK);
    assign txd_o = txd_q;

    always_comb begin
        state_d       = state_q;
        baud_d        = baud_q + BW'(1);
        bit_d         = bit_q;
        data_d        = data_q;
        txd_d         = txd_q;
        byte_if.ready = 1'b0;
        if (state_q == IDLE || tick) begin
            baud_d = '0;
        end
        unique case (state_q)
            IDLE: begin
                byte_if.ready = 1'b1;
                if (byte_if.valid) begin
                    state_d = START;
                    data_d  = byte_if.data;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                    txd_d   = data_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = ^data_q;
`else
                        state_d = STOP;
                        txd_d   = UART_IDLE_LEVEL;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = data_q[bit_q + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    txd_d   = UART_IDLE_LEVEL;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next start bit when a byte waits.
                if (tick) begin
                    byte_if.ready = 1'b1;
                    if (byte_if.valid) begin
                        state_d = START;
                        data_d  = byte_if.data;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = UART_IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            txd_q   <= UART_IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// 32-bit word transmitter: four back-to-back frames, LSB byte first.
// Define UART_TX_PARITY_EN for 8E1 framing; default is 8N1.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        TxD,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] LAST_BYTE = 2'(UART_BYTES_PER_WORD - 1);

    uart_byte_if byte_if ();

    logic [31:0] shreg_q, shreg_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        accept;

    assign accept     = word_valid && !busy_q;
    assign word_ready = !busy_q;
    assign busy       = busy_q;
    assign done       = done_q;

    always_comb begin
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        byte_if.valid = 1'b0;
        if (accept) begin
            shreg_d       = word_in;
            cnt_d         = '0;
            busy_d        = 1'b1;
            byte_if.valid = 1'b1;
        end else if (busy_q) begin
            byte_if.valid = (cnt_q != LAST_BYTE);
            if (byte_if.ready) begin
                if (cnt_q == LAST_BYTE) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 2'd1;
                    shreg_d = {8'h00, shreg_q[31:8]};
                end
            end
        end
        // The byte offered is always the low byte of the next register value.
        byte_if.data = shreg_d[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .byte_if (byte_if),
        .txd_o   (TxD)
    );

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx at CLKS_PER_BIT=4.
// Honours UART_TX_PARITY_EN for frame length and parity bits.
module tb_uart_word_tx;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    typedef struct {
        string       name;
        logic [31:0] word;
        logic [7:0]  b [4];
        logic [3:0]  par;
        int          pulse_at;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        TxD;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_bad = 0;

    uart_word_tx #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .TxD        (TxD),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [31:0] w,
                                input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input logic [3:0] par, input int pulse_at);
        vec_t v;
        v.name = name;
        v.word = w;
        v.b[0] = b0;
        v.b[1] = b1;
        v.b[2] = b2;
        v.b[3] = b3;
        v.par = par;
        v.pulse_at = pulse_at;
        return v;
    endfunction

    function automatic logic exp_bit(input logic [7:0] b, input logic p,
                                     input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9 && FB == 11) return p;
        return 1'b1;
    endfunction

    // Called at a negedge; the word is accepted on the following posedge.
    task automatic accept(input logic [31:0] w);
        int t = 0;
        while (word_ready !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept timeout: word_ready %b required 1", word_ready);
        end
        cmp("accept-cycle TxD", {31'd0, TxD}, 32'd1);
        word_in = w;
        word_valid = 1'b1;
        @(posedge clk);
        #1 word_valid = 1'b0;
    endtask

    // Starts right after the acceptance edge; ends at the done-cycle negedge.
    task automatic run_word(input vec_t v);
        logic [10:0] got;
        logic [10:0] exp;
        logic        bad;
        int          idx;
        for (int f = 0; f < 4; f++) begin
            got = '0;
            exp = '0;
            bad = 1'b0;
            for (int i = 0; i < FB; i++) begin
                exp[i] = exp_bit(v.b[f], v.par[f], i);
                for (int k = 0; k < N; k++) begin
                    @(negedge clk);
                    idx = (f * FB + i) * N + k;
                    if (idx == v.pulse_at) begin
                        word_in = 32'hDEADBEEF;
                        word_valid = 1'b1;
                    end else if (idx == v.pulse_at + 1) begin
                        word_valid = 1'b0;
                    end
                    if (k == 0) got[i] = TxD;
                    else if (TxD !== got[i]) bad = 1'b1;
                    if (done !== 1'b0 || busy !== 1'b1 || word_ready !== 1'b0)
                        bad = 1'b1;
                end
            end
            cmp($sformatf("%s frame%0d {glitch,bits}", v.name, f),
                {20'd0, bad, got}, {20'd0, 1'b0, exp});
        end
        @(negedge clk);
        cmp($sformatf("%s done-cycle {done,ready,busy,TxD}", v.name),
            {28'd0, done, word_ready, busy, TxD}, 32'b1101);
    endtask

    task automatic idle_check(input string name, input int cycles);
        int bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if ({TxD, word_ready, busy, done} !== 4'b1100) bad++;
        end
        cmp(name, bad, 0);
    endtask

    vec_t tbl [4];
    vec_t ca, cb, rv;

    initial begin
        tbl[0] = mk("w12345678", 32'h12345678, 8'h78, 8'h56, 8'h34, 8'h12, 4'b0100, 60);
        tbl[1] = mk("w00000701", 32'h00000701, 8'h01, 8'h07, 8'h00, 8'h00, 4'b0011, -10);
        tbl[2] = mk("wFFFFFFFF", 32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'b0000, -10);
        tbl[3] = mk("w80000001", 32'h80000001, 8'h01, 8'h00, 8'h00, 8'h80, 4'b1001, -10);
        ca = mk("wA5A5A5A5", 32'hA5A5A5A5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 4'b0000, -10);
        cb = mk("w00FF00FF", 32'h00FF00FF, 8'hFF, 8'h00, 8'hFF, 8'h00, 4'b0000, -10);
        rv = mk("w80000001-post-reset", 32'h80000001, 8'h01, 8'h00, 8'h00, 8'h80, 4'b1001, -10);

        repeat (3) @(negedge clk);
        cmp("reset {TxD,ready,busy,done}", {28'd0, TxD, word_ready, busy, done}, 32'b1100);
        rst_n = 1'b1;
        idle_check("idle 100 cycles bad count", 100);

        for (int t = 0; t < 4; t++) begin
            accept(tbl[t].word);
            run_word(tbl[t]);
        end

        // Back-to-back: valid held, second word taken in the done cycle.
        word_in = ca.word;
        word_valid = 1'b1;
        @(posedge clk);
        #1 word_in = cb.word;
        run_word(ca);
        @(posedge clk);
        #1 word_valid = 1'b0;
        run_word(cb);

        // Reset in byte 1 data bit 0 (0x56 bit 0 is low).
        @(negedge clk);
        accept(32'h12345678);
        repeat (46) @(negedge clk);
        cmp("pre-reset TxD", {31'd0, TxD}, 32'd0);
        #2 rst_n = 1'b0;
        #1 cmp("async reset {TxD,ready,busy,done}",
               {28'd0, TxD, word_ready, busy, done}, 32'b1100);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_check("post-reset idle bad count", 60);
        accept(rv.word);
        run_word(rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
